// File: rtl/pipe_stage_reg.sv
// Ready/valid pipeline register stage with saturating stall counter and flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry and fully register in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 135,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              stall_cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              in_xfer_s;
    logic              out_xfer_s;

    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = main_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;

    // Main/skid entry next-state; in_ready is only ever 1 while skid is empty.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_xfer_s) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = main_valid_q;
            end
        end else if (!main_valid_q || out_ready) begin
            main_valid_d = in_xfer_s;
            if (in_xfer_s) begin
                main_data_d = in_data;
            end else begin
                main_data_d = main_data_q;
            end
        end else begin
            if (in_xfer_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // Skid entry and registered in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_W{1'b0}};
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
    // Single entry: accept when empty or draining this cycle.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_xfer_s) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (out_xfer_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    assign in_ready  = ~main_valid_q | out_ready;
    assign occupancy = {1'b0, main_valid_q};
`endif

    // Stall counter: clear wins over the saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Main entry and stall counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= {DATA_W{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 135, payload width (two XLEN=64 data fields + 5-bit rd + 2 control bits).
REQ-002 Parameter CNT_W, default 32, stall counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a live payload.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_W  oldest held payload.
REQ-012 occupancy  output  2  live entries held, 0..1 (base) or 0..2 (skid build).
REQ-013 stall_cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-014 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Upstream transfer = in_valid & in_ready at a posedge; downstream transfer = out_valid & out_ready at a posedge.
REQ-016 Payloads leave in the order accepted; none duplicated or dropped except by flush/reset.
REQ-017 Latency: a payload accepted into an empty stage appears on out_data with out_valid=1 the next cycle.
REQ-018 Sustained throughput with out_ready=1 and in_valid=1: one transfer per cycle, no bubbles.
REQ-019 out_data holds its last value while out_valid=0; only reset zeroes it.
REQ-020 Simultaneous downstream and upstream transfer at occupancy 1: the new payload replaces the old, occupancy stays 1.
REQ-021 flush=1 at a posedge: all entries invalid next cycle, occupancy=0, the same-cycle in_data is discarded; flush overrides every transfer.
REQ-022 flush does not alter stall_cnt or out_data.
REQ-023 stall_cnt increments by 1 per cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
REQ-024 stall_cnt_clr=1 forces stall_cnt to 0 next cycle, overriding the increment.
REQ-025 in_valid=0 never changes held state except through out_ready transfers.

Reset
REQ-026 Asserting reset immediately forces out_valid=0, occupancy=0, out_data=0, stall_cnt=0, all internal entries invalid and zeroed, independent of clk.
REQ-027 During reset in_ready=1; reset released mid-handshake: no payload presented during reset is captured.
REQ-028 First transfer is possible at the first posedge after reset deasserts.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN selects the skid-buffer build.
REQ-030 Without it: one entry; in_ready = ~out_valid | out_ready, combinational from out_ready.
REQ-031 With it: main entry plus one skid entry; in_ready is a register output equal to "skid entry empty", no combinational out_ready->in_ready path.
REQ-032 Skid build: an upstream transfer while main is valid and not draining fills the skid entry (occupancy 2, in_ready=0 next cycle).
REQ-033 Skid build: downstream transfer at occupancy 2 moves skid to main next cycle, in_ready=1 next cycle; a same-cycle upstream transfer is impossible because in_ready=0.

Verification
REQ-034 Reset, then in_data=0x1 with in_valid=1, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0x1, occupancy=1; following cycle out_valid=0.
REQ-035 Stream 0x10..0x17 back to back, out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles, stall_cnt=0.
REQ-036 Hold out_ready=0 for 5 cycles with payload held -> stall_cnt=5, out_data unchanged; skid build: second payload accepted, occupancy=2, in_ready=0, release -> both appear in order.
REQ-037 flush pulsed with in_valid=1, in_data=0xAA at occupancy 1 (2 in skid) -> next cycle out_valid=0, occupancy=0, 0xAA never appears.
REQ-038 Assert reset asynchronously between edges at occupancy 1, stall_cnt=3 -> outputs zero before next posedge; CNT_W=2 bench: 6 stall cycles -> stall_cnt=3 (saturated); stall_cnt_clr -> 0.
